// File: rtl/tlb_lookup_unit_if.sv
// Request, response and page-table-walk handshake bundle for tlb_lookup_unit.
// The slave side is the TLB; the master side is the requester, the consumer and the walker.
interface tlb_lookup_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_paddr;
    logic        rsp_fault;
    logic        walk_req_valid;
    logic        walk_req_ready;
    logic [19:0] walk_req_vpn;
    logic        walk_rsp_valid;
    logic [19:0] walk_rsp_ppn;
    logic        walk_rsp_fault;

    modport slave (
        input  req_valid, req_vaddr, rsp_ready, walk_req_ready,
               walk_rsp_valid, walk_rsp_ppn, walk_rsp_fault,
        output req_ready, rsp_valid, rsp_paddr, rsp_fault,
               walk_req_valid, walk_req_vpn
    );

    modport master (
        output req_valid, req_vaddr, rsp_ready, walk_req_ready,
               walk_rsp_valid, walk_rsp_ppn, walk_rsp_fault,
        input  req_ready, rsp_valid, rsp_paddr, rsp_fault,
               walk_req_valid, walk_req_vpn
    );
endinterface

// File: rtl/tlb_lookup_unit.sv
// Fully-associative TLB front-end: hit returns {ppn, offset}, miss walks and refills.
// Define TLB_STATS_EN to add saturating hit_count/miss_count outputs.
module tlb_entry (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [19:0] wr_vpn,
    input  logic [19:0] wr_ppn,
    input  logic [19:0] lookup_vpn,
    output logic        valid,
    output logic        match,
    output logic [19:0] ppn
);
    logic [19:0] vpn_q;

    // A flush on the same edge as a fill leaves the entry invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            vpn_q <= '0;
            ppn   <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid <= 1'b1;
            vpn_q <= wr_vpn;
            ppn   <= wr_ppn;
        end
    end

    assign match = valid && (vpn_q == lookup_vpn);
endmodule

module tlb_lookup_unit #(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
`ifdef TLB_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    tlb_lookup_unit_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WALK_REQ, S_WALK_WAIT, S_RESP} state_t;

    state_t                    state, state_nx;
    logic [31:0]               vaddr_q;
    logic [19:0]               vpn;
    logic [ENTRIES-1:0]        ent_valid, ent_match, ent_wr;
    logic [ENTRIES-1:0][19:0]  ent_ppn;
    logic [19:0]               hit_ppn;
    logic                      hit, install, any_free, drop_fill;
    logic [IDX_W-1:0]          rr, victim;
    logic [31:0]               rsp_paddr_q;
    logic                      rsp_fault_q, walk_req_valid_q;
    logic [19:0]               walk_req_vpn_q;

    assign vpn     = vaddr_q[31:12];
    assign hit     = (|ent_match) && !flush;
    // drop_fill remembers a flush seen while the walk was outstanding.
    assign install = (state == S_WALK_WAIT) && bus.walk_rsp_valid && !bus.walk_rsp_fault
                     && !flush && !drop_fill;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        assign ent_wr[g] = install && (victim == IDX_W'(g));
        tlb_entry u_ent (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (flush),
            .wr_en      (ent_wr[g]),
            .wr_vpn     (vpn),
            .wr_ppn     (bus.walk_rsp_ppn),
            .lookup_vpn (vpn),
            .valid      (ent_valid[g]),
            .match      (ent_match[g]),
            .ppn        (ent_ppn[g])
        );
    end

    // Matches are one-hot (no duplicate VPNs are ever installed), so OR-merge is exact.
    always_comb begin
        hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (ent_match[i]) hit_ppn = hit_ppn | ent_ppn[i];
    end

    always_comb begin
        victim   = rr;
        any_free = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                victim   = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:      if (bus.req_valid)      state_nx = S_LOOKUP;
            S_LOOKUP:    state_nx = hit ? S_RESP : S_WALK_REQ;
            S_WALK_REQ:  if (bus.walk_req_ready) state_nx = S_WALK_WAIT;
            S_WALK_WAIT: if (bus.walk_rsp_valid) state_nx = S_RESP;
            S_RESP:      if (bus.rsp_ready)      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vaddr_q          <= '0;
            rsp_paddr_q      <= '0;
            rsp_fault_q      <= 1'b0;
            walk_req_valid_q <= 1'b0;
            walk_req_vpn_q   <= '0;
            rr               <= '0;
            drop_fill        <= 1'b0;
        end else begin
            if (install && !any_free) rr <= rr + IDX_W'(1);
            unique case (state)
                S_IDLE: if (bus.req_valid) vaddr_q <= bus.req_vaddr;
                S_LOOKUP: begin
                    if (hit) begin
                        rsp_paddr_q <= {hit_ppn, vaddr_q[11:0]};
                        rsp_fault_q <= 1'b0;
                    end else begin
                        walk_req_valid_q <= 1'b1;
                        walk_req_vpn_q   <= vpn;
                    end
                end
                S_WALK_REQ: begin
                    if (bus.walk_req_ready) begin
                        walk_req_valid_q <= 1'b0;
                        drop_fill        <= 1'b0;
                    end
                end
                S_WALK_WAIT: begin
                    if (flush) drop_fill <= 1'b1;
                    if (bus.walk_rsp_valid) begin
                        rsp_paddr_q <= bus.walk_rsp_fault ? 32'h0 : {bus.walk_rsp_ppn, vaddr_q[11:0]};
                        rsp_fault_q <= bus.walk_rsp_fault;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TLB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == S_LOOKUP) begin
            if (hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

    assign bus.req_ready      = (state == S_IDLE);
    assign bus.rsp_valid      = (state == S_RESP);
    assign bus.rsp_paddr      = rsp_paddr_q;
    assign bus.rsp_fault      = rsp_fault_q;
    assign bus.walk_req_valid = walk_req_valid_q;
    assign bus.walk_req_vpn   = walk_req_vpn_q;
endmodule
